// File: rtl/converter_telemetry_uart.sv
// rtl/converter_telemetry_uart.sv - buffers converter samples and sends them as 3-byte UART frames
// Frame is HEADER, sample, HEADER^sample; 8N1, LSB first, CLK_DIV clocks per bit.
module converter_telemetry_uart #(
   parameter int          CLK_DIV    = 868,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [7:0]  HEADER     = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_valid,
   input  logic [7:0] sample_data,
   input  logic       clear_overflow,
   output logic       tx,
   output logic       busy,
   output logic [4:0] fifo_count,
   output logic       overflow
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [4:0]    count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          full, push, pop;

   state_t        state_q;
   logic [TW-1:0] timer_q;
   logic [2:0]    bit_q;
   logic [1:0]    byte_q;
   logic [7:0]    shift_q, samp_q, cksum_q;
   logic          tx_q, busy_q;
   logic          bit_end;

   // A full FIFO drops the sample even if LOAD frees a slot in the same cycle.
   assign full    = (count_q == 5'(FIFO_DEPTH));
   assign push    = sample_valid && !full;
   assign pop     = (state_q == LOAD);
   assign bit_end = (timer_q == TW'(CLK_DIV - 1));

   always_comb begin
      count_d    = count_q + 5'(push) - 5'(pop);
      overflow_d = overflow_q;
      if (sample_valid && full) begin
         overflow_d = 1'b1;
      end else if (clear_overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= sample_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         samp_q  <= '0;
         cksum_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (count_q != 5'd0) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
               end
            end
            LOAD: begin
               samp_q  <= mem_q[rd_ptr_q];
               cksum_q <= HEADER ^ mem_q[rd_ptr_q];
               shift_q <= HEADER;
               byte_q  <= 2'd0;
               timer_q <= '0;
               tx_q    <= 1'b0;
               state_q <= START;
            end
            START: begin
               timer_q <= bit_end ? '0 : timer_q + TW'(1);
               if (bit_end) begin
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  bit_q   <= 3'd0;
                  state_q <= DATA;
               end
            end
            DATA: begin
               timer_q <= bit_end ? '0 : timer_q + TW'(1);
               if (bit_end) begin
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     tx_q    <= shift_q[0];
                     shift_q <= shift_q >> 1;
                     bit_q   <= bit_q + 3'd1;
                  end
               end
            end
            STOP: begin
               timer_q <= bit_end ? '0 : timer_q + TW'(1);
               if (bit_end) begin
                  if (byte_q < 2'd2) begin
                     byte_q  <= byte_q + 2'd1;
                     shift_q <= (byte_q == 2'd0) ? samp_q : cksum_q;
                     tx_q    <= 1'b0;
                     state_q <= START;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_converter_telemetry_uart.sv
// tb/tb_converter_telemetry_uart.sv - directed bench with UART byte scoreboard
// Expected bytes are queued when samples are driven; a serial monitor pops them.
module tb_converter_telemetry_uart;

   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_valid = 1'b0;
   logic [7:0] sample_data = 8'h00;
   logic       clear_overflow = 1'b0;
   logic       tx, busy, overflow;
   logic [4:0] fifo_count;

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q[$];
   logic       rst_evt = 1'b0;
   logic [4:0] peak = 5'd0;

   converter_telemetry_uart #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(4), .HEADER(8'hA5)) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
      .clear_overflow(clear_overflow), .tx(tx), .busy(busy),
      .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(posedge rst) rst_evt = 1'b1;
   always @(negedge clk) if (fifo_count > peak) peak = fifo_count;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic [7:0] ck);
      exp_q.push_back(8'hA5);
      exp_q.push_back(d);
      exp_q.push_back(ck);
   endtask

   task automatic push_sample(input logic [7:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic wait_tx_low(input string tag);
      int n = 0;
      while (tx !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, tx}, 32'd0);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0 || fifo_count !== 5'd0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_queue_empty"}, exp_q.size(), 0);
      chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   // Serial monitor: detects a start bit and samples every bit at its midpoint.
   initial begin
      logic [7:0] rx;
      logic       st, sp;
      logic [8:0] expb;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            rst_evt = 1'b0;
            repeat (CLK_DIV / 2) @(negedge clk);
            st = tx;
            for (int i = 0; i < 8; i++) begin
               repeat (CLK_DIV) @(negedge clk);
               rx[i] = tx;
            end
            repeat (CLK_DIV) @(negedge clk);
            sp = tx;
            if (!rst_evt && !rst) begin
               chk("rx_start_bit", {31'd0, st}, 32'd0);
               chk("rx_stop_bit", {31'd0, sp}, 32'd1);
               expb = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
               chk("rx_byte", {24'd0, rx}, {23'd0, expb});
            end
         end
      end
   end

   initial begin
      int n;
      // Reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_tx", {31'd0, tx}, 32'd1);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_count", {27'd0, fifo_count}, 32'd0);
         chk("rst_ovf", {31'd0, overflow}, 32'd0);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Single sample: latency and frame length
      expect_frame(8'h96, 8'h33);
      push_sample(8'h96);
      chk("t2_count_after_push", {27'd0, fifo_count}, 32'd1);
      @(negedge clk);
      chk("t2_load_busy", {31'd0, busy}, 32'd1);
      chk("t2_load_tx", {31'd0, tx}, 32'd1);
      @(negedge clk);
      chk("t2_start_tx", {31'd0, tx}, 32'd0);
      chk("t2_popped", {27'd0, fifo_count}, 32'd0);
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         n++;
         @(negedge clk);
      end
      chk("t2_frame_cycles", n, 120);
      chk("t2_tx_idle", {31'd0, tx}, 32'd1);
      drain("t2");

      // Back-to-back samples
      peak = 5'd0;
      expect_frame(8'h96, 8'h33);
      expect_frame(8'h2D, 8'h88);
      expect_frame(8'hFF, 8'h5A);
      sample_valid = 1'b1;
      sample_data = 8'h96;
      @(negedge clk);
      sample_data = 8'h2D;
      @(negedge clk);
      sample_data = 8'hFF;
      @(negedge clk);
      sample_valid = 1'b0;
      drain("t3");
      chk("t3_peak_count", {27'd0, peak}, 32'd2);

      // Overflow while a frame is in flight
      expect_frame(8'h77, 8'hD2);
      push_sample(8'h77);
      repeat (4) @(negedge clk);
      expect_frame(8'h11, 8'hB4);
      expect_frame(8'h22, 8'h87);
      expect_frame(8'h33, 8'h96);
      expect_frame(8'h44, 8'hE1);
      push_sample(8'h11);
      push_sample(8'h22);
      push_sample(8'h33);
      push_sample(8'h44);
      chk("t4_ovf_before_drop", {31'd0, overflow}, 32'd0);
      push_sample(8'h55);
      chk("t4_count_full", {27'd0, fifo_count}, 32'd4);
      chk("t4_ovf_set", {31'd0, overflow}, 32'd1);
      repeat (10) @(negedge clk);
      chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

      // Drop and clear in the same cycle: set wins
      clear_overflow = 1'b1;
      push_sample(8'h66);
      clear_overflow = 1'b0;
      chk("t5_set_wins", {31'd0, overflow}, 32'd1);
      chk("t5_count_full", {27'd0, fifo_count}, 32'd4);
      clear_overflow = 1'b1;
      @(negedge clk);
      clear_overflow = 1'b0;
      chk("t5_cleared", {31'd0, overflow}, 32'd0);
      drain("t4");

      // Reset during byte 1 data bits
      expect_frame(8'h5A, 8'hFF);
      push_sample(8'h5A);
      wait_tx_low("t6_frame_start");
      repeat (50) @(negedge clk);
      push_sample(8'h12);
      chk("t6_count_before_rst", {27'd0, fifo_count}, 32'd1);
      rst = 1'b1;
      #1;
      chk("t6_rst_tx", {31'd0, tx}, 32'd1);
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      chk("t6_rst_count", {27'd0, fifo_count}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      repeat (50) @(negedge clk);
      chk("t6_stay_idle", {31'd0, busy}, 32'd0);
      expect_frame(8'h3C, 8'h99);
      push_sample(8'h3C);
      drain("t6");
      chk("t6_end_count", {27'd0, fifo_count}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
